// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter: shares one CONNECT send port among NUM_REQ local sources.
// Packet-granular round-robin arbitration with per-VC credit flow control.
//
// Handshake: a requester holds req_valid together with its flit fields, and the
// flit is taken in every cycle where req_valid[i] && req_ready[i]. req_ready is
// combinational and only ever raised for the current packet owner. It depends
// only on registered state, the owner's req_valid and the credit for the latched
// VC. A taken flit appears on flit_out/send_flit exactly one cycle later.
module noc_inject_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 32,
    parameter int DEST_W      = 4,
    parameter int VC_W        = 1,
    parameter int CREDIT_INIT = 8,
    parameter int CNT_W       = 4,
    localparam int NUM_VCS    = 2 ** VC_W,
    localparam int FLIT_W     = 2 + DEST_W + VC_W + DATA_W,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ*DEST_W-1:0]  req_dest,
    input  logic [NUM_REQ*VC_W-1:0]    req_vc,
    input  logic [NUM_REQ-1:0]         req_tail,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [FLIT_W-1:0]          flit_out,
    output logic                       send_flit,
    input  logic [VC_W:0]              credit_in,
    output logic                       en_get_credit,
    output logic [ID_W-1:0]            grant_id,
    output logic                       busy,
    output logic                       err_credit_ovf,
    output logic [0:0]                 dbgState,
    output logic [ID_W-1:0]            dbgRrPtr,
    output logic [NUM_VCS*CNT_W-1:0]   dbgCredit
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arbStateT;

    arbStateT          state;
    logic [ID_W-1:0]   rrPtr;
    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   pick;
    logic [ID_W-1:0]   nextPtr;
    logic              anyValid;
    logic [DEST_W-1:0] lDest;
    logic [VC_W-1:0]   lVc;
    logic [CNT_W-1:0]  credit [NUM_VCS];
    logic              xfer;
    logic              creditValid;
    logic [VC_W-1:0]   creditVc;
    logic [NUM_VCS-1:0] incVc;
    logic [NUM_VCS-1:0] decVc;

    assign creditValid = credit_in[VC_W];
    assign creditVc    = credit_in[VC_W-1:0];
    assign busy        = (state == LOCK);
    assign grant_id    = owner;
    assign dbgState    = state;
    assign dbgRrPtr    = rrPtr;
    assign xfer        = |req_ready;
    assign nextPtr     = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + ID_W'(1);

    // Round-robin scan: walk downwards so the closest valid requester at or after rrPtr wins.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = rrPtr;
        anyValid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rrPtr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[idx]) begin
                pick     = ID_W'(idx);
                anyValid = 1'b1;
            end
        end
    end

    // Only the owner may be accepted, and only while its latched VC has credit.
    always_comb begin
        req_ready = '0;
        if (state == LOCK && req_valid[owner] && credit[lVc] != '0) begin
            req_ready[owner] = 1'b1;
        end
    end

    // One-hot credit return and consumption per VC for this cycle.
    always_comb begin
        incVc = '0;
        decVc = '0;
        if (creditValid) begin
            incVc[creditVc] = 1'b1;
        end
        if (xfer) begin
            decVc[lVc] = 1'b1;
        end
    end

    // Flatten the credit counters for observation.
    always_comb begin
        dbgCredit = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            dbgCredit[v*CNT_W +: CNT_W] = credit[v];
        end
    end

    // Arbitration FSM with registered flit output; one bubble per packet for the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rrPtr         <= '0;
            owner         <= '0;
            lDest         <= '0;
            lVc           <= '0;
            flit_out      <= '0;
            send_flit     <= 1'b0;
            en_get_credit <= 1'b0;
        end else begin
            en_get_credit <= 1'b1;
            send_flit     <= xfer;
            flit_out      <= xfer ? {1'b1, req_tail[owner], lDest, lVc,
                                     req_data[owner*DATA_W +: DATA_W]} : '0;
            case (state)
                IDLE: begin
                    if (anyValid) begin
                        owner <= pick;
                        lDest <= req_dest[pick*DEST_W +: DEST_W];
                        lVc   <= req_vc[pick*VC_W +: VC_W];
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (xfer && req_tail[owner]) begin
                        state <= IDLE;
                        rrPtr <= nextPtr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Credit counters: send and return on the same VC cancel; a return to a full counter
    // saturates and raises the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                credit[v] <= CNT_W'(CREDIT_INIT);
            end
            err_credit_ovf <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (incVc[v] && !decVc[v]) begin
                    if (credit[v] == CNT_W'(CREDIT_INIT)) begin
                        err_credit_ovf <= 1'b1;
                    end else begin
                        credit[v] <= credit[v] + CNT_W'(1);
                    end
                end else if (decVc[v] && !incVc[v]) begin
                    credit[v] <= credit[v] - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Testbench for noc_inject_arbiter: directed scenarios followed by a randomized
// phase, all checked every cycle against a packet-level reference model.
module tb_noc_inject_arbiter;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int DSTW = 4;
    localparam int VCW  = 1;
    localparam int CI   = 8;
    localparam int CNTW = 4;
    localparam int FW   = 2 + DSTW + VCW + DW;
    localparam int IDW  = 2;

    typedef struct {
        logic            tail;
        logic [DSTW-1:0] dest;
        logic            vc;
        logic [DW-1:0]   data;
    } srcT;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N*DSTW-1:0] req_dest;
    logic [N*VCW-1:0]  req_vc;
    logic [N-1:0]      req_tail;
    logic [N-1:0]      req_ready;
    logic [FW-1:0]     flit_out;
    logic              send_flit;
    logic [VCW:0]      credit_in;
    logic              en_get_credit;
    logic [IDW-1:0]    grant_id;
    logic              busy;
    logic              err_credit_ovf;
    logic [0:0]        dbgState;
    logic [IDW-1:0]    dbgRrPtr;
    logic [2*CNTW-1:0] dbgCredit;

    // Reference model state
    srcT            srcQ [N][$];
    logic [FW-1:0]  exp_q[$];
    logic [DW-1:0]  sentLog[$];
    bit             mBusy;
    bit             mErr;
    bit             mEn;
    int             mOwner;
    int             mPtr;
    logic [DSTW-1:0] mDest;
    logic           mVc;
    int             mCredit [2];

    int nChecks = 0;
    int nPass   = 0;

    noc_inject_arbiter #(
        .NUM_REQ(N), .DATA_W(DW), .DEST_W(DSTW), .VC_W(VCW),
        .CREDIT_INIT(CI), .CNT_W(CNTW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_dest(req_dest),
        .req_vc(req_vc), .req_tail(req_tail), .req_ready(req_ready),
        .flit_out(flit_out), .send_flit(send_flit),
        .credit_in(credit_in), .en_get_credit(en_get_credit),
        .grant_id(grant_id), .busy(busy), .err_credit_ovf(err_credit_ovf),
        .dbgState(dbgState), .dbgRrPtr(dbgRrPtr), .dbgCredit(dbgCredit)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", nPass, nChecks);
        $fatal(1, "simulation timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nChecks++;
        assert (obs === expv) nPass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic srcT mk(input logic tail, input logic [DSTW-1:0] dest,
                               input logic vc, input logic [DW-1:0] data);
        srcT f;
        f.tail = tail; f.dest = dest; f.vc = vc; f.data = data;
        return f;
    endfunction

    function automatic bit pending();
        bit p = 0;
        for (int i = 0; i < N; i++) if (srcQ[i].size() > 0) p = 1;
        return p;
    endfunction

    task automatic drive(input logic [N-1:0] gate, input logic cv, input logic cvc);
        for (int i = 0; i < N; i++) begin
            if (srcQ[i].size() > 0) begin
                req_valid[i]              = gate[i];
                req_tail[i]               = srcQ[i][0].tail;
                req_dest[i*DSTW +: DSTW]  = srcQ[i][0].dest;
                req_vc[i]                 = srcQ[i][0].vc;
                req_data[i*DW +: DW]      = srcQ[i][0].data;
            end else begin
                req_valid[i] = 1'b0;
                req_tail[i]  = 1'b0;
            end
        end
        credit_in = {cv, cvc};
    endtask

    // Per-cycle comparison of every output against the model.
    task automatic check_cycle();
        logic [N-1:0]  expRdy;
        logic [FW-1:0] e;
        expRdy = '0;
        if (mBusy && req_valid[mOwner] && mCredit[mVc] > 0) expRdy[mOwner] = 1'b1;
        chk("req_ready", req_ready, expRdy);
        chk("busy", busy, mBusy);
        chk("grant_id", grant_id, mOwner);
        chk("en_get_credit", en_get_credit, mEn);
        chk("err_credit_ovf", err_credit_ovf, mErr);
        if (send_flit === 1'b1) sentLog.push_back(flit_out[DW-1:0]);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("send_flit", send_flit, 1);
            chk("flit_out", flit_out, e);
        end else begin
            chk("send_flit", send_flit, 0);
            chk("flit_valid", flit_out[FW-1], 0);
        end
    endtask

    // Advance the model across one clock edge using the inputs just driven.
    task automatic model_step();
        int  acc;
        int  dec;
        int  inc;
        bit  tailTaken;
        srcT f;
        acc = -1;
        tailTaken = 0;
        if (mBusy && req_valid[mOwner] && mCredit[mVc] > 0) acc = mOwner;
        if (acc >= 0) begin
            f = srcQ[acc].pop_front();
            exp_q.push_back({1'b1, f.tail, mDest, mVc, f.data});
            tailTaken = f.tail;
        end
        dec = (acc >= 0) ? int'(mVc) : -1;
        inc = credit_in[1] ? int'(credit_in[0]) : -1;
        if (inc >= 0 && inc != dec) begin
            if (mCredit[inc] == CI) mErr = 1;
            else mCredit[inc]++;
        end
        if (dec >= 0 && dec != inc) mCredit[dec]--;
        if (!mBusy) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (mPtr + k) % N;
                if (!mBusy && req_valid[j]) begin
                    mOwner = j;
                    mDest  = srcQ[j][0].dest;
                    mVc    = srcQ[j][0].vc;
                    mBusy  = 1;
                end
            end
        end else if (acc >= 0 && tailTaken) begin
            mBusy = 0;
            mPtr  = (mOwner + 1) % N;
        end
        mEn = 1;
    endtask

    task automatic tick(input logic [N-1:0] gate, input logic cv, input logic cvc);
        drive(gate, cv, cvc);
        @(negedge clk);
        check_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        req_valid = '0;
        req_tail  = '0;
        req_data  = '0;
        req_dest  = '0;
        req_vc    = '0;
        credit_in = '0;
        repeat (n) @(posedge clk);
        #1;
        mBusy = 0; mErr = 0; mEn = 0; mOwner = 0; mPtr = 0; mDest = '0; mVc = 1'b0;
        mCredit[0] = CI; mCredit[1] = CI;
        exp_q.delete();
        sentLog.delete();
        for (int i = 0; i < N; i++) srcQ[i].delete();
        chk("rst_send_flit", send_flit, 0);
        chk("rst_flit_out", flit_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_rr_ptr", dbgRrPtr, 0);
        chk("rst_state", dbgState, 0);
        chk("rst_credits", dbgCredit, {4'd8, 4'd8});
        chk("rst_err", err_credit_ovf, 0);
        chk("rst_en_get_credit", en_get_credit, 0);
        rst = 1'b0;
    endtask

    task automatic run_until_idle(input int limit, input bit giveCredits);
        int   n;
        int   v;
        logic cv;
        n = 0;
        while ((pending() || mBusy || exp_q.size() > 0) && n < limit) begin
            v  = $urandom_range(0, 1);
            cv = giveCredits && (mCredit[v] < CI);
            tick('1, cv, v[0]);
            n++;
        end
        chk("drain_bound", (n < limit), 1);
    endtask

    initial begin
        logic [DW-1:0] expOrder [8];
        int n;

        // 1: reset held two cycles
        do_reset(2);

        // 2: single 3-flit packet; body dest/vc differ from head and must be ignored
        srcQ[0].push_back(mk(1'b0, 4'd5, 1'b0, 32'h0000_000A));
        srcQ[0].push_back(mk(1'b0, 4'd9, 1'b1, 32'h0000_000B));
        srcQ[0].push_back(mk(1'b1, 4'd3, 1'b1, 32'h0000_000C));
        run_until_idle(30, 0);
        chk("t2_sent_count", sentLog.size(), 3);
        chk("t2_last_data", sentLog[2], 32'hC);
        chk("t2_credit_vc0", dbgCredit[3:0], 5);
        chk("t2_credit_vc1", dbgCredit[7:4], 8);
        chk("t2_rr_ptr", dbgRrPtr, 1);

        // 3: two competing requesters alternate packet by packet
        do_reset(2);
        for (int p = 0; p < 2; p++) begin
            srcQ[0].push_back(mk(1'b0, 4'd1, 1'b0, 32'h100 + 2*p));
            srcQ[0].push_back(mk(1'b1, 4'd1, 1'b0, 32'h101 + 2*p));
            srcQ[2].push_back(mk(1'b0, 4'd2, 1'b1, 32'h200 + 2*p));
            srcQ[2].push_back(mk(1'b1, 4'd2, 1'b1, 32'h201 + 2*p));
        end
        expOrder = '{32'h100, 32'h101, 32'h200, 32'h201, 32'h102, 32'h103, 32'h202, 32'h203};
        run_until_idle(40, 1);
        chk("t3_sent_count", sentLog.size(), 8);
        for (int k = 0; k < 8; k++) chk("t3_order", sentLog[k], expOrder[k]);

        // 4: credit exhaustion stalls, one return releases exactly one flit
        do_reset(2);
        for (int k = 0; k < 10; k++)
            srcQ[1].push_back(mk(k == 9, 4'd7, 1'b1, 32'h400 + k));
        repeat (12) tick('1, 1'b0, 1'b0);
        chk("t4_stalled_count", sentLog.size(), 8);
        chk("t4_credit_vc1", dbgCredit[7:4], 0);
        chk("t4_busy", busy, 1);
        tick('1, 1'b1, 1'b1);
        tick('1, 1'b0, 1'b0);
        tick('1, 1'b0, 1'b0);
        chk("t4_after_return", sentLog.size(), 9);
        run_until_idle(60, 1);
        chk("t4_total", sentLog.size(), 10);

        // 5: same-VC send and return cancel; return to a full counter is flagged
        do_reset(2);
        srcQ[0].push_back(mk(1'b0, 4'd4, 1'b0, 32'h500));
        srcQ[0].push_back(mk(1'b1, 4'd4, 1'b0, 32'h501));
        run_until_idle(20, 0);
        chk("t5_credit_vc0_a", dbgCredit[3:0], 6);
        srcQ[0].push_back(mk(1'b1, 4'd4, 1'b0, 32'h502));
        n = 0;
        while ((pending() || mBusy || exp_q.size() > 0) && n < 20) begin
            tick('1, mBusy && (srcQ[mOwner].size() > 0), 1'b0);
            n++;
        end
        chk("t5_credit_vc0_same", dbgCredit[3:0], 6);
        chk("t5_err_clear", err_credit_ovf, 0);
        tick('1, 1'b1, 1'b0);
        tick('1, 1'b1, 1'b0);
        chk("t5_credit_full", dbgCredit[3:0], 8);
        tick('1, 1'b1, 1'b0);
        repeat (3) tick('1, 1'b0, 1'b0);
        chk("t5_err_sticky", err_credit_ovf, 1);
        chk("t5_credit_sat", dbgCredit[3:0], 8);

        // 6: reset in the middle of a packet
        do_reset(2);
        srcQ[2].push_back(mk(1'b1, 4'd2, 1'b0, 32'h600));
        for (int k = 0; k < 4; k++)
            srcQ[3].push_back(mk(k == 3, 4'd8, 1'b1, 32'h610 + k));
        n = 0;
        while (srcQ[3].size() > 2 && n < 20) begin
            tick('1, 1'b0, 1'b0);
            n++;
        end
        chk("t6_reach_bound", (n < 20), 1);
        chk("t6_rr_ptr_before", dbgRrPtr, 3);
        do_reset(1);

        // Randomized traffic with random valid gaps and credit returns
        do_reset(2);
        for (int c = 0; c < 800; c++) begin
            logic [N-1:0] gate;
            int v;
            logic cv;
            for (int i = 0; i < N; i++) begin
                if (srcQ[i].size() < 2 && $urandom_range(0, 3) == 0) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int k = 0; k < len; k++)
                        srcQ[i].push_back(mk(k == len - 1, 4'($urandom_range(0, 15)),
                                             1'($urandom_range(0, 1)), $urandom));
                end
                gate[i] = ($urandom_range(0, 9) != 0);
            end
            v  = $urandom_range(0, 1);
            cv = (mCredit[v] < CI) && ($urandom_range(0, 2) != 0);
            tick(gate, cv, v[0]);
        end
        run_until_idle(600, 1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
